// File: rtl/cursor_input_ctrl_if.sv
// Bundle of the raw pushbuttons feeding the cursor controller and the
// registered cursor/brush state it hands to the paint stage.
interface cursor_input_ctrl_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_tool;
    logic       btn_size;
    logic       btn_color;
    logic [9:0] X_POS;
    logic [9:0] Y_POS;
    logic [2:0] color;
    logic       tool_on;
    logic       size_sel;

    // Controller side: reads buttons, drives cursor and brush state.
    modport master (
        input  btn_up, btn_down, btn_left, btn_right,
        input  btn_tool, btn_size, btn_color,
        output X_POS, Y_POS, color, tool_on, size_sel
    );

    // Board/consumer side: drives buttons, reads cursor and brush state.
    modport slave (
        output btn_up, btn_down, btn_left, btn_right,
        output btn_tool, btn_size, btn_color,
        input  X_POS, Y_POS, color, tool_on, size_sel
    );
endinterface

// File: rtl/cursor_input_ctrl.sv
// Cursor input controller: synchronizes and debounces seven pushbuttons,
// moves a clamped cursor with hold-to-repeat, and toggles/cycles the
// brush controls. All outputs come straight from flops.
module cursor_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int STEP_CYCLES     = 1000000,
    parameter int X_MAX           = 639,
    parameter int Y_MAX           = 479,
    parameter int X_INIT          = 320,
    parameter int Y_INIT          = 240
) (
    input  logic                  clk,
    input  logic                  clr,
    cursor_input_ctrl_if.master   bus
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

    // Button bit order: 0 up, 1 down, 2 left, 3 right, 4 tool, 5 size, 6 color
    logic [6:0] raw;
    assign raw = {bus.btn_color, bus.btn_size, bus.btn_tool,
                  bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

    logic [6:0]    sync1_q, sync2_q;
    logic [6:0]    stable_q, stable_d, stable_dly_q;
    logic [DW-1:0] db_cnt_q [7];
    logic [DW-1:0] db_cnt_d [7];
    logic [6:0]    press;

    typedef enum logic {IDLE, HOLD} move_state_t;
    move_state_t   state_q;
    logic [SW-1:0] step_cnt_q;
    logic [9:0]    x_q, y_q, x_step, y_step;
    logic [2:0]    color_q, color_d;
    logic          tool_q, tool_d, size_q, size_d;

    // Two-flop synchronizer bringing the asynchronous buttons into clk.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a level is accepted only after DEBOUNCE_CYCLES differing samples.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 7; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce state plus a delayed copy of the stable levels for edge detect.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int i = 0; i < 7; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            for (int i = 0; i < 7; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign press = stable_q & ~stable_dly_q;

    // Brush controls react to single-cycle press pulses; colour wraps in 3 bits.
    always_comb begin
        tool_d  = tool_q ^ press[4];
        size_d  = size_q ^ press[5];
        color_d = color_q + {2'b00, press[6]};
    end

    // Brush control registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            tool_q  <= 1'b0;
            size_q  <= 1'b0;
            color_q <= 3'd0;
        end else begin
            tool_q  <= tool_d;
            size_q  <= size_d;
            color_q <= color_d;
        end
    end

    // One clamped step from the held directions; 11-bit math exposes underflow.
    always_comb begin
        logic [10:0] x_dec, x_inc, y_dec, y_inc;
        x_dec  = {1'b0, x_q} - 11'd1;
        x_inc  = {1'b0, x_q} + 11'd1;
        y_dec  = {1'b0, y_q} - 11'd1;
        y_inc  = {1'b0, y_q} + 11'd1;
        x_step = x_q;
        y_step = y_q;
        if (stable_q[2] && !stable_q[3]) begin
            if (!x_dec[10]) x_step = x_dec[9:0];
        end else if (stable_q[3] && !stable_q[2]) begin
            if (x_inc <= 11'(X_MAX)) x_step = x_inc[9:0];
        end
        if (stable_q[0] && !stable_q[1]) begin
            if (!y_dec[10]) y_step = y_dec[9:0];
        end else if (stable_q[1] && !stable_q[0]) begin
            if (y_inc <= 11'(Y_MAX)) y_step = y_inc[9:0];
        end
    end

    // Move FSM: immediate step on first press, then one step per STEP_CYCLES.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= IDLE;
            step_cnt_q <= '0;
            x_q        <= 10'(X_INIT);
            y_q        <= 10'(Y_INIT);
        end else begin
            case (state_q)
                IDLE: begin
                    step_cnt_q <= '0;
                    if (|stable_q[3:0]) begin
                        x_q     <= x_step;
                        y_q     <= y_step;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (!(|stable_q[3:0])) begin
                        state_q    <= IDLE;
                        step_cnt_q <= '0;
                    end else if (step_cnt_q == STEP_LAST) begin
                        x_q        <= x_step;
                        y_q        <= y_step;
                        step_cnt_q <= '0;
                    end else begin
                        step_cnt_q <= step_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    step_cnt_q <= '0;
                end
            endcase
        end
    end

    assign bus.X_POS    = x_q;
    assign bus.Y_POS    = y_q;
    assign bus.color    = color_q;
    assign bus.tool_on  = tool_q;
    assign bus.size_sel = size_q;

endmodule

// File: tb/tb_cursor_input_ctrl.sv
// Directed testbench for cursor_input_ctrl with short debounce/step periods.
module tb_cursor_input_ctrl;

    localparam logic [6:0] BTN_NONE  = 7'b0000000;
    localparam logic [6:0] BTN_UP    = 7'b0000001;
    localparam logic [6:0] BTN_DOWN  = 7'b0000010;
    localparam logic [6:0] BTN_LEFT  = 7'b0000100;
    localparam logic [6:0] BTN_RIGHT = 7'b0001000;
    localparam logic [6:0] BTN_TOOL  = 7'b0010000;
    localparam logic [6:0] BTN_SIZE  = 7'b0100000;
    localparam logic [6:0] BTN_COLOR = 7'b1000000;

    logic clk;
    logic clr;
    int   vectorCount;
    int   failCount;

    cursor_input_ctrl_if bus ();

    cursor_input_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .STEP_CYCLES     (8),
        .X_MAX           (639),
        .Y_MAX           (479),
        .X_INIT          (320),
        .Y_INIT          (240)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the seven raw buttons from one vector
    task automatic applyStimulus(input logic [6:0] btns);
        bus.btn_up    = btns[0];
        bus.btn_down  = btns[1];
        bus.btn_left  = btns[2];
        bus.btn_right = btns[3];
        bus.btn_tool  = btns[4];
        bus.btn_size  = btns[5];
        bus.btn_color = btns[6];
    endtask

    // Advance n rising edges and settle 1 ns past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare one observed value with its expected value
    task automatic checkOutput(input string tag, input int actual, input int expected);
        vectorCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Pulse reset for two cycles, then release
    task automatic resetPulse();
        clr = 1'b0;
        tick(2);
        clr = 1'b1;
        tick(1);
    endtask

    initial begin
        vectorCount = 0;
        failCount   = 0;
        applyStimulus(BTN_NONE);
        clr = 1'b0;
        tick(3);
        checkOutput("rst_x_in_reset", int'(bus.X_POS), 320);
        clr = 1'b1;
        tick(1);
        checkOutput("rst_x", int'(bus.X_POS), 320);
        checkOutput("rst_y", int'(bus.Y_POS), 240);
        checkOutput("rst_color", int'(bus.color), 0);
        checkOutput("rst_tool", int'(bus.tool_on), 0);
        checkOutput("rst_size", int'(bus.size_sel), 0);

        // Right held 30 cycles
        applyStimulus(BTN_RIGHT);
        tick(6);
        checkOutput("right_edge6", int'(bus.X_POS), 320);
        tick(1);
        checkOutput("right_edge7", int'(bus.X_POS), 321);
        tick(8);
        checkOutput("right_edge15", int'(bus.X_POS), 322);
        tick(8);
        checkOutput("right_edge23", int'(bus.X_POS), 323);
        checkOutput("right_y", int'(bus.Y_POS), 240);
        tick(7);
        applyStimulus(BTN_NONE);
        tick(20);
        checkOutput("right_after_release", int'(bus.X_POS), 324);

        // Tool glitch then real press
        applyStimulus(BTN_TOOL);
        tick(3);
        applyStimulus(BTN_NONE);
        tick(15);
        checkOutput("tool_glitch", int'(bus.tool_on), 0);
        applyStimulus(BTN_TOOL);
        tick(6);
        checkOutput("tool_edge6", int'(bus.tool_on), 0);
        tick(1);
        checkOutput("tool_edge7", int'(bus.tool_on), 1);
        tick(3);
        applyStimulus(BTN_NONE);
        tick(20);
        checkOutput("tool_release", int'(bus.tool_on), 1);

        // Colour cycled nine times
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(BTN_COLOR);
            tick(10);
            applyStimulus(BTN_NONE);
            tick(10);
            checkOutput($sformatf("color_press%0d", i), int'(bus.color), i % 8);
        end

        // Up and down together cancel
        applyStimulus(BTN_UP | BTN_DOWN);
        tick(20);
        checkOutput("updown_y", int'(bus.Y_POS), 240);
        checkOutput("updown_x", int'(bus.X_POS), 324);
        applyStimulus(BTN_NONE);
        tick(20);

        // Diagonal up+left from reset position
        resetPulse();
        applyStimulus(BTN_UP | BTN_LEFT);
        tick(6);
        checkOutput("diag_edge6_x", int'(bus.X_POS), 320);
        tick(1);
        checkOutput("diag_edge7_x", int'(bus.X_POS), 319);
        checkOutput("diag_edge7_y", int'(bus.Y_POS), 239);
        applyStimulus(BTN_NONE);
        tick(20);
        checkOutput("diag_final_x", int'(bus.X_POS), 319);
        checkOutput("diag_final_y", int'(bus.Y_POS), 239);

        // Simultaneous brush presses
        applyStimulus(BTN_TOOL | BTN_SIZE | BTN_COLOR);
        tick(7);
        checkOutput("multi_tool", int'(bus.tool_on), 1);
        checkOutput("multi_size", int'(bus.size_sel), 1);
        checkOutput("multi_color", int'(bus.color), 1);
        applyStimulus(BTN_NONE);
        tick(20);

        // Left edge clamp: 320 steps reach 0
        resetPulse();
        applyStimulus(BTN_LEFT);
        tick(2551);
        checkOutput("left_x1", int'(bus.X_POS), 1);
        tick(8);
        checkOutput("left_x0", int'(bus.X_POS), 0);
        tick(40);
        checkOutput("left_clamp", int'(bus.X_POS), 0);
        applyStimulus(BTN_NONE);
        tick(20);

        // Bottom edge clamp: 239 steps reach 479
        resetPulse();
        applyStimulus(BTN_DOWN);
        tick(1911);
        checkOutput("down_y479", int'(bus.Y_POS), 479);
        tick(40);
        checkOutput("down_clamp", int'(bus.Y_POS), 479);
        checkOutput("down_x", int'(bus.X_POS), 320);
        applyStimulus(BTN_NONE);
        tick(20);

        // Reset during a hold, then re-debounce
        resetPulse();
        applyStimulus(BTN_RIGHT);
        tick(15);
        checkOutput("hold_x322", int'(bus.X_POS), 322);
        clr = 1'b0;
        #1;
        checkOutput("async_reset_x", int'(bus.X_POS), 320);
        tick(2);
        clr = 1'b1;
        tick(6);
        checkOutput("rehold_edge6", int'(bus.X_POS), 320);
        tick(1);
        checkOutput("rehold_edge7", int'(bus.X_POS), 321);
        applyStimulus(BTN_NONE);
        tick(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

endmodule

// File: doc/cursor_input_ctrl.md
Name: cursor_input_ctrl

Overview:
- Upstream stage of the VGA paint top level; sole producer of its X_POS, Y_POS, color, tool_on and size_sel inputs.
- Converts raw board pushbuttons into debounced press events.
- Moves a clamped 640x480 cursor with hold-to-repeat and toggles/cycles the brush controls.
- All outputs are registered, in the 100 MHz clk domain.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronized samples needed to accept a level change (10 ms at 100 MHz).
- STEP_CYCLES, 1000000: cycles between repeat steps while a direction is held (100 px/s).
- X_MAX, 639: largest legal X_POS.
- Y_MAX, 479: largest legal Y_POS.
- X_INIT, 320: X_POS reset value.
- Y_INIT, 240: Y_POS reset value.

Ports:
- clk  in  1  master clock, 100 MHz
- clr  in  1  reset; asynchronous, active-low (clr=0 resets)
- btn_up  in  1  raw pushbutton, asynchronous
- btn_down  in  1  raw pushbutton
- btn_left  in  1  raw pushbutton
- btn_right  in  1  raw pushbutton
- btn_tool  in  1  raw pushbutton; toggles tool_on
- btn_size  in  1  raw pushbutton; toggles size_sel
- btn_color  in  1  raw pushbutton; cycles color
- X_POS  out  10  cursor column, 0..X_MAX
- Y_POS  out  10  cursor row, 0..Y_MAX
- color  out  3  brush colour index
- tool_on  out  1  drawing enabled
- size_sel  out  1  brush size select

Behaviour:
- Reset (clr=0, async): X_POS=X_INIT, Y_POS=Y_INIT, color=0, tool_on=0, size_sel=0.
- Reset also clears all synchronizers, debounce stable levels and counters, and the move FSM (state IDLE, step counter 0).
- Reset mid-hold discards the hold. After release, any button still pressed must be re-debounced before it takes effect.
- Synchronizer: each of the 7 buttons passes through a 2-flop synchronizer; its output is s.
- Debounce, per button, with a stable level and a counter cnt:
  - s==stable: cnt<=0.
  - s!=stable and cnt==DEBOUNCE_CYCLES-1: stable<=s, cnt<=0.
  - Otherwise: cnt<=cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES samples is ignored.
- Press event: press = stable & ~stable_d (one-cycle pulse).
- Latency: a clean raw press held continuously changes the affected output exactly DEBOUNCE_CYCLES+3 clk edges after the raw input rises.
- Brush controls (outputs update on the edge after the press pulse):
  - tool press: tool_on <= ~tool_on.
  - size press: size_sel <= ~size_sel.
  - color press: color <= color+1, wrapping 7 -> 0.
  - Simultaneous presses of different controls all take effect in the same cycle.
- Step operation, computed from the debounced direction levels (up/down/left/right):
  - dy = -1 if up only, +1 if down only, 0 if neither or both.
  - dx = -1 if left only, +1 if right only, 0 if neither or both.
  - Diagonal moves are legal.
  - Clamp: X_POS never goes below 0 or above X_MAX; Y_POS never goes below 0 or above Y_MAX. A move past an edge leaves that coordinate unchanged, with no wrap.
- Move FSM:
  - IDLE: if any direction level is high, perform one step, set step counter to 0, go to HOLD.
  - HOLD:
    - If no direction level is high: go to IDLE; counter reset to 0.
    - Else if counter==STEP_CYCLES-1: perform one step using the currently held directions; counter<=0.
    - Else: counter<=counter+1.
    - A direction newly pressed while in HOLD does not step immediately; it joins the next repeat step.
- Consequence: a held button yields its first step on debounce acceptance (+1 cycle), then one step every STEP_CYCLES cycles.
- Widths: counters sized as clog2 of their parameter. Coordinate arithmetic uses 11 bits so underflow is detected before clamping.

Test Plan:
(Parameters DEBOUNCE_CYCLES=4, STEP_CYCLES=8, defaults elsewhere.)
- Reset, then release: X_POS=320, Y_POS=240, color=0, tool_on=0, size_sel=0 on the first cycle after clr rises.
- btn_right rises and holds for 30 cycles:
  - X_POS=321 at edge 7 after the rise.
  - X_POS=322 at edge 15, 323 at edge 23.
  - Y_POS stays 240.
- btn_tool pulses for 3 cycles (glitch) -> tool_on stays 0. btn_tool held for 10 cycles -> tool_on=1 at edge 7; no further change on release.
- btn_color pressed 9 times, each held 10 cycles with 10-cycle gaps -> color steps 1..7, 0, 1.
- Up and down held together -> Y_POS unchanged. Up and left held together -> X_POS=319 and Y_POS=239 on the same cycle.
- Edge clamping, reached by holding the relevant directions from reset:
  - With X_POS=0, hold left for 40 cycles -> X_POS stays 0.
  - Drive to Y_POS=479, hold down -> Y_POS stays 479.
  - Assert clr=0 mid-hold -> X_POS=320 immediately (asynchronous), and no step occurs after release until the button is re-debounced.
